// File: rtl/y86_pkg.sv
// Shared Y86 constants: ALU/condition function codes, icodes,
// register ids and the execute-unit FSM state type.
package y86_pkg;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;
    localparam logic [3:0] ALU_MUL = 4'h4;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_RSP  = 4'h4;
    localparam logic [3:0] R_NONE = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/y86_mul_iter.sv
// Iterative signed multiplier: shift-add on operand magnitudes,
// MUL_STEP multiplier bits per cycle, sign applied at the end.
module y86_mul_iter #(
    parameter int DATA_W   = 64,
    parameter int MUL_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] prod_lo,
    output logic              ovf
);

    localparam int N  = DATA_W / MUL_STEP;
    localparam int CW = $clog2(N + 1);
    localparam int PW = 2 * DATA_W;

    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     step_sum;
    logic [PW-1:0]     prod_full;
    logic [DATA_W:0]   prod_hi;
    logic [DATA_W-1:0] a_mag, b_mag;

    // accumulate this step's partial products and form the signed result
    always_comb begin
        step_sum = acc_q;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier_q[i]) begin
                step_sum = step_sum + (mcand_q << i);
            end
        end
        prod_full = neg_q ? -step_sum : step_sum;
        a_mag = a[DATA_W-1] ? -a : a;
        b_mag = b[DATA_W-1] ? -b : b;
    end

    assign prod_hi = prod_full[PW-1:DATA_W-1];
    assign prod_lo = prod_full[DATA_W-1:0];
    assign ovf     = !((&prod_hi) | ~(|prod_hi));
    assign done    = (cnt_q == CW'(1));

    // load magnitudes on start, otherwise retire MUL_STEP bits per cycle
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{DATA_W{1'b0}}, a_mag};
            mplier_d = b_mag;
            neg_d    = a[DATA_W-1] ^ b[DATA_W-1];
            cnt_d    = CW'(N);
        end else if (cnt_q != '0) begin
            acc_d    = step_sum;
            mcand_d  = mcand_q << MUL_STEP;
            mplier_d = mplier_q >> MUL_STEP;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    // multiplier state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/y86_alu_cc_unit.sv
// Y86 execute unit: handshaked ALU, iterative MUL, CC register
// and branch/cmov condition evaluation.
module y86_alu_cc_unit
    import y86_pkg::*;
#(
    parameter int         DATA_W   = 64,
    parameter int         MUL_STEP = 1,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic [3:0]        alu_fun,
    input  logic              set_cc,
    input  logic [3:0]        cond_fun,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] val_e,
    output logic              cnd,
    output logic              err,
    output logic              cc_zf,
    output logic              cc_sf,
    output logic              cc_of
);

    localparam int M = DATA_W - 1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] val_e_q, val_e_d;
    logic              cnd_q, cnd_d;
    logic              err_q, err_d;
    logic [2:0]        cc_q, cc_d;
    logic              set_cc_q, set_cc_d;

    logic              accept, bad, is_mul, mul_start;
    logic              mul_done, mul_ovf;
    logic [DATA_W-1:0] mul_lo;
    logic [DATA_W-1:0] alu_r;
    logic              alu_of, cond_now;
    logic              zf, sf, of;
    logic [2:0]        flags_alu, flags_mul;

    assign in_ready  = (state_q == S_IDLE)
                     | ((state_q == S_HOLD) & out_ready);
    assign accept    = in_valid & in_ready;
    assign bad       = (alu_fun > ALU_MUL) | (cond_fun > C_G);
    assign is_mul    = (alu_fun == ALU_MUL);
    assign mul_start = accept & is_mul & ~bad;

    assign {zf, sf, of} = cc_q;
    assign flags_alu = {alu_r == '0, alu_r[M], alu_of};
    assign flags_mul = {mul_lo == '0, mul_lo[M], mul_ovf};

    y86_mul_iter #(
        .DATA_W   (DATA_W),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (alu_a),
        .b       (alu_b),
        .done    (mul_done),
        .prod_lo (mul_lo),
        .ovf     (mul_ovf)
    );

    // single-cycle ALU result and its signed overflow
    always_comb begin
        alu_r  = '0;
        alu_of = 1'b0;
        case (alu_fun)
            ALU_ADD: begin
                alu_r  = alu_a + alu_b;
                alu_of = (alu_a[M] == alu_b[M])
                       & (alu_r[M] != alu_a[M]);
            end
            ALU_SUB: begin
                alu_r  = alu_b - alu_a;
                alu_of = (alu_a[M] != alu_b[M])
                       & (alu_r[M] != alu_b[M]);
            end
            ALU_AND: alu_r = alu_a & alu_b;
            ALU_XOR: alu_r = alu_a ^ alu_b;
            default: ;
        endcase
    end

    // condition from the CC value in force before this operation
    always_comb begin
        cond_now = 1'b0;
        case (cond_fun)
            C_YES:   cond_now = 1'b1;
            C_LE:    cond_now = (sf ^ of) | zf;
            C_L:     cond_now = sf ^ of;
            C_E:     cond_now = zf;
            C_NE:    cond_now = !zf;
            C_GE:    cond_now = !(sf ^ of);
            C_G:     cond_now = !(sf ^ of) & !zf;
            default: ;
        endcase
    end

    // next state, result capture and CC update
    always_comb begin
        state_d  = state_q;
        val_e_d  = val_e_q;
        cnd_d    = cnd_q;
        err_d    = err_q;
        cc_d     = cc_q;
        set_cc_d = set_cc_q;
        if (accept) begin
            set_cc_d = set_cc;
            err_d    = bad;
            cnd_d    = bad ? 1'b0 : cond_now;
            if (bad) begin
                state_d = S_HOLD;
                val_e_d = '0;
            end else if (is_mul) begin
                state_d = S_BUSY;
            end else begin
                state_d = S_HOLD;
                val_e_d = alu_r;
                if (set_cc) begin
                    cc_d = flags_alu;
                end
            end
        end else begin
            unique case (state_q)
                S_BUSY: begin
                    if (mul_done) begin
                        state_d = S_HOLD;
                        val_e_d = mul_lo;
                        if (set_cc_q) begin
                            cc_d = flags_mul;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // state and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            val_e_q  <= '0;
            cnd_q    <= 1'b0;
            err_q    <= 1'b0;
            cc_q     <= CC_RESET;
            set_cc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            val_e_q  <= val_e_d;
            cnd_q    <= cnd_d;
            err_q    <= err_d;
            cc_q     <= cc_d;
            set_cc_q <= set_cc_d;
        end
    end

    assign out_valid = (state_q == S_HOLD);
    assign val_e     = val_e_q;
    assign cnd       = cnd_q;
    assign err       = err_q;
    assign {cc_zf, cc_sf, cc_of} = cc_q;

endmodule

// File: tb/tb_y86_alu_cc_unit.sv
// Randomised bench for y86_alu_cc_unit with an arithmetic reference
// model; a 32-bit/4-step instance covers the narrow configuration.
module tb_y86_alu_cc_unit;

    typedef struct {
        logic [63:0] val;
        logic        cnd;
        logic        err;
        logic [2:0]  cc;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [63:0] alu_a, alu_b, val_e;
    logic [3:0]  alu_fun, cond_fun;
    logic        set_cc, cnd, err, cc_zf, cc_sf, cc_of;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [31:0] s_alu_a, s_alu_b, s_val_e;
    logic [3:0]  s_alu_fun, s_cond_fun;
    logic        s_set_cc, s_cnd, s_err, s_cc_zf, s_cc_sf, s_cc_of;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          stall = 0;
    exp_t        q[$];
    bit          front_seen = 0;
    logic [2:0]  mcc = 3'b100;
    logic [2:0]  scc = 3'b100;

    y86_alu_cc_unit u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_fun   (alu_fun),
        .set_cc    (set_cc),
        .cond_fun  (cond_fun),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .val_e     (val_e),
        .cnd       (cnd),
        .err       (err),
        .cc_zf     (cc_zf),
        .cc_sf     (cc_sf),
        .cc_of     (cc_of)
    );

    y86_alu_cc_unit #(.DATA_W(32), .MUL_STEP(4)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .alu_a     (s_alu_a),
        .alu_b     (s_alu_b),
        .alu_fun   (s_alu_fun),
        .set_cc    (s_set_cc),
        .cond_fun  (s_cond_fun),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .val_e     (s_val_e),
        .cnd       (s_cnd),
        .err       (s_err),
        .cc_zf     (s_cc_zf),
        .cc_sf     (s_cc_sf),
        .cc_of     (s_cc_of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] sx(input logic [63:0] x,
                                        input int w);
        logic [127:0] r;
        r = {64'd0, x};
        for (int i = w; i < 128; i++) r[i] = x[w-1];
        return r;
    endfunction

    // reference: exact-width arithmetic, overflow = not representable
    function automatic exp_t model(input logic [63:0] a, b,
                                   input logic [3:0] f,
                                   input logic sc,
                                   input logic [3:0] c,
                                   input logic [2:0] cc,
                                   input int w, input int mul_cycles);
        exp_t e;
        logic [127:0] sa, sb, full;
        logic [63:0]  mask, res;
        logic         z, s, o, ovf, bad, lt;
        z = cc[2]; s = cc[1]; o = cc[0];
        lt = s ^ o;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        sa = sx(a, w);
        sb = sx(b, w);
        case (f)
            4'd0: full = sa + sb;
            4'd1: full = sb - sa;
            4'd2: full = sa & sb;
            4'd3: full = sa ^ sb;
            4'd4: full = sa * sb;
            default: full = '0;
        endcase
        res = full[63:0] & mask;
        ovf = (f == 4'd0 || f == 4'd1 || f == 4'd4)
              && (full != sx(res, w));
        bad = (f > 4'd4) || (c > 4'd6);
        case (c)
            4'd0: e.cnd = 1'b1;
            4'd1: e.cnd = lt | z;
            4'd2: e.cnd = lt;
            4'd3: e.cnd = z;
            4'd4: e.cnd = !z;
            4'd5: e.cnd = !lt;
            4'd6: e.cnd = !lt && !z;
            default: e.cnd = 1'b0;
        endcase
        e.acc = 0;
        e.lat = (!bad && f == 4'd4) ? mul_cycles + 1 : 1;
        if (bad) begin
            e.val = '0;
            e.cnd = 1'b0;
            e.err = 1'b1;
            e.cc  = cc;
        end else begin
            e.val = res;
            e.err = 1'b0;
            e.cc  = sc ? {res == 64'd0, res[w-1], ovf} : cc;
        end
        return e;
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'h8000_0000_0000_0000;
            2: return '1;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            4: return 64'($urandom_range(0, 20));
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // consumer handshake: forced stalls, otherwise mostly ready
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // compare process: every cycle, DUT against the model queue
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (q.size() == 0) begin
                    chk("idle_out_valid", 64'(out_valid), 64'd0);
                    chk("idle_in_ready", 64'(in_ready), 64'd1);
                    chk("idle_cc", 64'({cc_zf, cc_sf, cc_of}), 64'(mcc));
                end else if (out_valid) begin
                    if (!front_seen) begin
                        chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
                        front_seen = 1;
                    end
                    chk("val_e", val_e, q[0].val);
                    chk("cnd", 64'(cnd), 64'(q[0].cnd));
                    chk("err", 64'(err), 64'(q[0].err));
                    chk("cc", 64'({cc_zf, cc_sf, cc_of}), 64'(q[0].cc));
                    chk("hold_in_ready", 64'(in_ready), 64'(out_ready));
                    if (out_ready) begin
                        void'(q.pop_front());
                        front_seen = 0;
                    end
                end else begin
                    chk("busy_in_ready", 64'(in_ready), 64'd0);
                    chk("busy_late", 64'((cyc - q[0].acc) < q[0].lat), 64'd1);
                end
            end
        end
    end

    // offer one op; returns one cycle after it was accepted
    task automatic issue(input logic [63:0] a, b, input logic [3:0] f,
                         input logic sc, input logic [3:0] c);
        exp_t e;
        int   t;
        alu_a = a; alu_b = b; alu_fun = f; set_cc = sc; cond_fun = c;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        e = model(a, b, f, sc, c, mcc, 64, 64);
        e.acc = cyc;
        mcc = e.cc;
        q.push_back(e);
        @(negedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 500) begin
            @(negedge clk);
            #2;
            t++;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    // narrow instance: one op at a time, always-ready consumer
    task automatic s_op(input logic [31:0] a, b, input logic [3:0] f,
                        input logic sc, input logic [3:0] c);
        exp_t e;
        int   lat;
        e = model({32'd0, a}, {32'd0, b}, f, sc, c, scc, 32, 8);
        scc = e.cc;
        s_alu_a = a; s_alu_b = b; s_alu_fun = f;
        s_set_cc = sc; s_cond_fun = c; s_in_valid = 1'b1;
        chk("s_in_ready", 64'(s_in_ready), 64'd1);
        @(negedge clk);
        #2;
        s_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < 40) begin
            @(negedge clk);
            #2;
            lat++;
        end
        chk("s_latency", 64'(lat), 64'(e.lat));
        chk("s_val_e", {32'd0, s_val_e}, e.val);
        chk("s_cnd", 64'(s_cnd), 64'(e.cnd));
        chk("s_err", 64'(s_err), 64'(e.err));
        chk("s_cc", 64'({s_cc_zf, s_cc_sf, s_cc_of}), 64'(e.cc));
        @(negedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d miscompares",
                 miscompares);
        $fatal(1);
    end

    initial begin
        exp_t m;
        logic [3:0] f, c;
        rst_n = 1'b0;
        in_valid = 1'b0; alu_a = '0; alu_b = '0;
        alu_fun = '0; set_cc = 1'b0; cond_fun = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b1; s_alu_a = '0;
        s_alu_b = '0; s_alu_fun = '0; s_set_cc = 1'b0; s_cond_fun = '0;

        // pin the model with hand-computed values
        m = model(64'd5, 64'd7, 4'd0, 1'b1, 4'd0, 3'b100, 64, 64);
        chk("pin_add", m.val, 64'd12);
        chk("pin_add_cc", 64'(m.cc), 64'd0);
        m = model(64'd1, 64'h8000_0000_0000_0000, 4'd1, 1'b1, 4'd0,
                  3'b100, 64, 64);
        chk("pin_sub", m.val, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("pin_sub_cc", 64'(m.cc), 64'b001);
        m = model(64'd0, 64'd0, 4'd2, 1'b0, 4'd2, 3'b001, 64, 64);
        chk("pin_cond_l", 64'(m.cnd), 64'd1);
        m = model(-64'd3, 64'd7, 4'd4, 1'b1, 4'd0, 3'b100, 64, 64);
        chk("pin_mul", m.val, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("pin_mul_lat", 64'(m.lat), 64'd65);
        m = model(64'h4000_0000_0000_0000, 64'd4, 4'd4, 1'b1, 4'd0,
                  3'b000, 64, 64);
        chk("pin_mul_ovf", 64'(m.cc), 64'b101);
        m = model(64'd6, 64'd7, 4'd4, 1'b1, 4'd0, 3'b100, 32, 8);
        chk("pin_mul32", m.val, 64'd42);

        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        chk("rst_val_e", val_e, 64'd0);
        chk("rst_cnd", 64'(cnd), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_cc", 64'({cc_zf, cc_sf, cc_of}), 64'b100);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        issue(64'd5, 64'd7, 4'd0, 1'b1, 4'd0);
        issue(64'd1, 64'h8000_0000_0000_0000, 4'd1, 1'b1, 4'd0);
        issue(64'd0, 64'd0, 4'd2, 1'b0, 4'd2);
        issue(-64'd3, 64'd7, 4'd4, 1'b1, 4'd0);
        issue(64'h4000_0000_0000_0000, 64'd4, 4'd4, 1'b1, 4'd3);
        drain();

        stall = 6;
        issue(64'h1234, 64'h1, 4'd0, 1'b1, 4'd0);
        issue(64'hF0, 64'hFF, 4'd3, 1'b1, 4'd0);
        issue(64'd1, 64'd2, 4'd9, 1'b1, 4'd0);
        issue(64'd1, 64'd2, 4'd0, 1'b1, 4'd7);
        issue(64'd0, 64'd0, 4'd2, 1'b0, 4'd3);
        drain();

        issue(64'd9, 64'd9, 4'd4, 1'b1, 4'd0);
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        front_seen = 0;
        mcc = 3'b100;
        scc = 3'b100;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        chk("rst_mul_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mul_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mul_cc", 64'({cc_zf, cc_sf, cc_of}), 64'b100);
        repeat (3) @(negedge clk);
        #2;

        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 15))
                0, 1, 2: f = 4'd4;
                15:      f = 4'($urandom_range(5, 15));
                default: f = 4'($urandom_range(0, 3));
            endcase
            c = ($urandom_range(0, 15) == 0) ? 4'd7
                                             : 4'($urandom_range(0, 6));
            issue(rnd64(), rnd64(), f, 1'($urandom_range(0, 1)), c);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                #2;
            end
        end
        drain();

        s_op(32'd6, 32'd7, 4'd4, 1'b1, 4'd0);
        s_op(32'h8000_0000, 32'hFFFF_FFFF, 4'd4, 1'b1, 4'd0);
        s_op(32'h7FFF_FFFF, 32'd1, 4'd0, 1'b1, 4'd6);
        for (int i = 0; i < 20; i++) begin
            f = 4'($urandom_range(0, 5));
            s_op($urandom(), $urandom(), f, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
